// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: start/busy/done handshake and operand/result bus for the BCD-to-binary converter
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  ovf;
  logic                  err;
  modport master (output start, bcd_in, input busy, done, bin_out, ovf, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, ovf, err);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential reverse double dabble, one shift-and-correct step per clock.
// Optional digit check enabled by defining BCD2BIN_CHECK_EN (invalid digits finish immediately with err=1).
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  bcd_to_binary_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t           state;
  logic [BW-1:0]    bcd_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcd_sh;
  logic [BW-1:0]    bcd_nxt;
  logic [BIN_W-1:0] bin_nxt;
  assign {bcd_sh, bin_nxt} = {bcd_reg, bin_reg} >> 1;
  // each digit is corrected independently after the shift; no carries cross digit boundaries
  for (genvar i = 0; i < DIGITS; i++) begin : g_corr
    assign bcd_nxt[4*i +: 4] = (bcd_sh[4*i +: 4] >= 4'd8) ? bcd_sh[4*i +: 4] - 4'd3 : bcd_sh[4*i +: 4];
  end
`ifdef BCD2BIN_CHECK_EN
  logic bad;
  logic err_pend;
  // flags any operand digit above 9 at the moment of acceptance
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (bus.bcd_in[4*i +: 4] > 4'd9);
  end
`else
  assign bus.err = 1'b0;
`endif
  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bin_out <= '0;
      bus.ovf     <= 1'b0;
`ifdef BCD2BIN_CHECK_EN
      err_pend    <= 1'b0;
      bus.err     <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bcd_reg  <= bus.bcd_in;
          bin_reg  <= '0;
          cnt      <= CW'(BIN_W);
          bus.busy <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
          err_pend <= bad;
          state    <= bad ? FINISH : SHIFT;
`else
          state    <= SHIFT;
`endif
        end
        SHIFT: begin
          bcd_reg <= bcd_nxt;
          bin_reg <= bin_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
`ifdef BCD2BIN_CHECK_EN
          bus.bin_out <= err_pend ? '0 : bin_reg;
          bus.ovf     <= !err_pend && (bcd_reg != '0);
          bus.err     <= err_pend;
`else
          bus.bin_out <= bin_reg;
          bus.ovf     <= (bcd_reg != '0);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter using reverse double dabble: one shift-and-correct step per clock.
- It is the decode direction of the team's binary-to-BCD display path. It turns DIGITS packed BCD digits into an unsigned binary value for the arithmetic logic.
- Start/busy/done handshake; also flags overflow and invalid digits.

Parameters:
- DIGITS, 3, number of packed BCD digits on bcd_in (digit 0 in bits [3:0]).
- BIN_W, 10, width of bin_out and number of shift iterations; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD operand; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/ovf/err are valid.
- bin_out  output  BIN_W  converted value; held until the next done.
- ovf  output  1  BCD value >= 2^BIN_W; bin_out = value mod 2^BIN_W.
- err  output  1  a digit > 9 was present (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, bin_out=0, ovf=0, err=0.
  - Iteration counter, BCD shift register and binary shift register are cleared.
  - Reset asserted mid-conversion aborts the conversion with no done pulse.
  - Deassertion is synchronous to clk by the system; there is no extra internal synchroniser.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with start=1, bcd_in is loaded into the BCD register, the binary register is cleared and cnt=BIN_W.
  - The FSM moves to SHIFT and busy=1 from that edge.
  - A start present while done=1 is accepted normally.
- SHIFT, on each edge:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1.
  - Then, for each digit of the shifted bcd_reg, subtract 3 if the digit is >= 8.
  - Decrement cnt.
  - On the edge where cnt reaches 0, go to FINISH.
- FINISH, one edge:
  - bin_out <= bin_reg.
  - ovf <= (bcd_reg != 0).
  - done <= 1, busy <= 0, return to IDLE.
  - done clears on the following edge.
- Latency: done is high in the cycle after edge number BIN_W+1 counted from the load edge (load edge = edge 0).
  - BIN_W=10: done is visible after edge 11.
- start while busy=1 is ignored; it is not queued.
- bcd_in changes after the load edge have no effect.
- Correction is applied after the shift, never before the first shift.
- All arithmetic is unsigned and per 4-bit digit; there are no carries between digits.

Optional Feature:
- Macro: BCD2BIN_CHECK_EN
- Defined:
  - On the load edge, any digit of bcd_in > 9 sends the FSM straight to FINISH with no shifts.
  - Next edge: done=1, err=1, bin_out=0, ovf=0.
  - Valid operands give err=0 and unchanged latency.
- Undefined:
  - No digit check; err is tied to 0.
  - Invalid digits go through the algorithm unchanged and the result is not specified.

Test Plan:
- DIGITS=3, BIN_W=10, bcd_in=12'h255, start pulse -> busy for 11 edges, done pulse, bin_out=10'd255, ovf=0, err=0.
- bcd_in=12'h999 -> bin_out=10'd999 (0x3E7), ovf=0; then bcd_in=12'h000 -> bin_out=0, done still on the same latency.
- BIN_W=8, bcd_in=12'h300 -> done after 9 edges, ovf=1, bin_out=8'd44.
- BCD2BIN_CHECK_EN defined, bcd_in=12'h1A5 -> done on the edge after load, err=1, bin_out=0. Without the macro, err stays 0.
- Second start pulse during busy with bcd_in=12'h111 -> ignored; result is from the first operand, and exactly one done pulse occurs.
- rst_n pulled low 4 edges into a conversion -> busy, done and bin_out go to 0 immediately and no done follows. After release, start with 12'h042 -> bin_out=42.
